// File: rtl/ram_dma_pkg.sv
// Shared constants and state encoding for the RAM DMA engine.
package ram_dma_pkg;

    localparam int unsigned AW_DEFAULT = 14;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

endpackage

// File: rtl/ram_dma.sv
// RAM DMA engine: ascending byte copy (read/write pairs) or byte fill over a
// single-port synchronous RAM. Pointers wrap modulo 2^AW.
// Optional feature: define RAM_DMA_FILL_EN to enable fill mode; otherwise
// every transfer is a copy and d follows q.
module ram_dma
    import ram_dma_pkg::*;
#(
    parameter int unsigned AW = AW_DEFAULT
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          fill,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW:0]   len,
    input  logic [7:0]    value,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] a,
    output logic [7:0]    d,
    output logic          w,
    input  logic [7:0]    q
);

    localparam int unsigned CW = AW + 1;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] src_ptr;
    logic [AW-1:0] src_nxt;
    logic [AW-1:0] dst_ptr;
    logic [AW-1:0] dst_nxt;
    logic [AW-1:0] a_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          w_nxt;
    logic          done_nxt;
    logic          load;
    logic          fill_sel;
    logic          fill_mode;

`ifdef RAM_DMA_FILL_EN
    logic          fill_q;
    logic [7:0]    value_q;

    assign fill_sel  = fill;
    assign fill_mode = fill_q;

    // Capture transfer mode and fill byte when a transfer is accepted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fill_q  <= 1'b0;
            value_q <= 8'h00;
        end else if (load) begin
            fill_q  <= fill;
            value_q <= value;
        end
    end

    // Write data: fill byte in fill mode, otherwise the byte just read.
    assign d = fill_q ? value_q : q;
`else
    logic unused_fill;

    assign fill_sel    = 1'b0;
    assign fill_mode   = 1'b0;
    assign unused_fill = ^{fill, value};

    // Copy-only build: write data is always the byte just read.
    assign d = q;
`endif

    // Next-state, pointer and RAM-port decode.
    always_comb begin
        state_nxt = state;
        src_nxt   = src_ptr;
        dst_nxt   = dst_ptr;
        cnt_nxt   = cnt;
        a_nxt     = a;
        w_nxt     = 1'b0;
        done_nxt  = 1'b0;
        load      = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (len == CW'(0)) begin
                        done_nxt = 1'b1;
                    end else begin
                        load    = 1'b1;
                        src_nxt = src;
                        dst_nxt = dst;
                        cnt_nxt = len;
                        if (fill_sel) begin
                            state_nxt = WR;
                            a_nxt     = dst;
                            w_nxt     = 1'b1;
                        end else begin
                            state_nxt = RD;
                            a_nxt     = src;
                        end
                    end
                end
            end
            RD: begin
                state_nxt = WR;
                a_nxt     = dst_ptr;
                w_nxt     = 1'b1;
            end
            WR: begin
                src_nxt = src_ptr + AW'(1);
                dst_nxt = dst_ptr + AW'(1);
                cnt_nxt = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else if (fill_mode) begin
                    a_nxt = dst_ptr + AW'(1);
                    w_nxt = 1'b1;
                end else begin
                    state_nxt = RD;
                    a_nxt     = src_ptr + AW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, pointers, count and registered RAM-port/status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            src_ptr <= '0;
            dst_ptr <= '0;
            cnt     <= '0;
            a       <= '0;
            w       <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            src_ptr <= src_nxt;
            dst_ptr <= dst_nxt;
            cnt     <= cnt_nxt;
            a       <= a_nxt;
            w       <= w_nxt;
            done    <= done_nxt;
            busy    <= (state_nxt != IDLE);
        end
    end

endmodule
